// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver_if
// Description : Bundle between the datapath and the seven-segment scan driver.
//               Carries the four hex digits, per-digit enables and load strobe
//               toward the driver, plus the anode/segment/select/frame outputs
//               back toward the board pins and external muxes.
// Ports (modport slave = driver side):
//   d0..d3     in   4  hex value per digit (d0 is rightmost)
//   en_in      in   4  per-digit enable, bit k shows digit k
//   load       in   1  single-cycle capture strobe
//   an         out  4  anodes, active-low
//   seg        out  7  segments {g,f,e,d,c,b,a}, active-low
//   sel        out  2  digit slot currently scanned
//   frame_done out  1  one-cycle pulse at the frame wrap
// Revision    : 1.0  initial release
// ============================================================================
interface seg_scan_driver_if;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] en_in;
  logic       load;
  logic [3:0] an;
  logic [6:0] seg;
  logic [1:0] sel;
  logic       frame_done;

  modport master (
    output d0, d1, d2, d3, en_in, load,
    input  an, seg, sel, frame_done
  );

  modport slave (
    input  d0, d1, d2, d3, en_in, load,
    output an, seg, sel, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed 4-digit common-anode seven-segment driver.
//               Each digit slot lasts REFRESH_DIV clocks: BLANK_CYCLES with all
//               anodes off (ghost suppression) followed by the digit itself.
//               New digits are double-buffered and only become visible at the
//               frame wrap so a frame never mixes old and new values.
// Ports:
//   clk    in  1   system clock, rising edge
//   rst_n  in  1   asynchronous active-low reset
//   bus    slave modport of seg_scan_driver_if (digits, enables, load in;
//          an, seg, sel, frame_done out - all outputs registered)
// Revision    : 1.0  initial release
// ============================================================================
module seg_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int DIV_W        = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  seg_scan_driver_if.slave   bus
);

  localparam logic [DIV_W-1:0] C_DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] C_BLANK_LAST = DIV_W'(BLANK_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_next;
  logic [1:0]       r_sel;
  logic [1:0]       w_sel_next;
  logic             r_frame_done;
  logic [3:0]       r_an;
  logic [3:0]       w_an_next;
  logic [6:0]       r_seg;
  logic [6:0]       w_seg_next;
  logic [15:0]      r_pend_digits;
  logic [15:0]      w_pend_digits_next;
  logic [3:0]       r_pend_en;
  logic [3:0]       w_pend_en_next;
  logic [15:0]      r_disp_digits;
  logic [15:0]      w_disp_digits_next;
  logic [3:0]       r_disp_en;
  logic [3:0]       w_disp_en_next;
  logic             w_slot_end;
  logic             w_wrap;
  logic [3:0]       w_digit;

  // Active-low {g,f,e,d,c,b,a} hex font.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BLANK;
      r_cnt         <= '0;
      r_sel         <= 2'd0;
      r_frame_done  <= 1'b0;
      r_an          <= 4'b1111;
      r_seg         <= 7'b1111111;
      r_pend_digits <= '0;
      r_pend_en     <= 4'b0000;
      r_disp_digits <= '0;
      r_disp_en     <= 4'b0000;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_sel         <= w_sel_next;
      r_frame_done  <= w_wrap;
      r_an          <= w_an_next;
      r_seg         <= w_seg_next;
      r_pend_digits <= w_pend_digits_next;
      r_pend_en     <= w_pend_en_next;
      r_disp_digits <= w_disp_digits_next;
      r_disp_en     <= w_disp_en_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_slot_end         = (r_cnt == C_DIV_LAST);
    w_wrap             = w_slot_end && (r_sel == 2'd3);
    w_cnt_next         = w_slot_end ? '0 : r_cnt + 1'b1;
    w_sel_next         = w_slot_end ? r_sel + 2'd1 : r_sel;

    // A load coinciding with the wrap goes straight through to the display
    // because the display copies the *next* pending value, not the current one.
    w_pend_digits_next = bus.load ? {bus.d3, bus.d2, bus.d1, bus.d0} : r_pend_digits;
    w_pend_en_next     = bus.load ? bus.en_in : r_pend_en;
    w_disp_digits_next = w_wrap ? w_pend_digits_next : r_disp_digits;
    w_disp_en_next     = w_wrap ? w_pend_en_next : r_disp_en;

    case (r_state)
      ST_BLANK: if (r_cnt == C_BLANK_LAST) w_state_next = ST_SHOW;
      ST_SHOW:  if (w_slot_end)            w_state_next = ST_BLANK;
      default:                             w_state_next = ST_BLANK;
    endcase

    // Outputs are computed from the next-cycle state so that the registered
    // an/seg line up exactly with the registered state and select.
    w_digit    = w_disp_digits_next[{w_sel_next, 2'b00} +: 4];
    w_an_next  = 4'b1111;
    w_seg_next = 7'b1111111;
    if ((w_state_next == ST_SHOW) && w_disp_en_next[w_sel_next]) begin
      w_an_next  = ~(4'b0001 << w_sel_next);
      w_seg_next = hex_to_seg(w_digit);
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.sel        = r_sel;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
